// File: rtl/constants_pkg.sv
// Shared decode constants: ALU operation select, RV32I opcodes,
// immediate formats and the decode-to-execute bundle.
package constants;

  typedef enum logic [3:0] {
    ALU_PASS = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SLL  = 4'd3,
    ALU_SLT  = 4'd4,
    ALU_SLTU = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_OR   = 4'd9,
    ALU_AND  = 4'd10,
    ALU_EQ   = 4'd11,
    ALU_NE   = 4'd12,
    ALU_SGE  = 4'd13,
    ALU_SGEU = 4'd14
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_e;

  typedef struct packed {
    alu_op_e     alu_op;
    logic [31:0] oper1;
    logic [31:0] oper2;
    logic [31:0] store_data;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_we;
    logic        is_branch;
    logic        is_jump;
    logic        is_load;
    logic        is_store;
    logic        illegal;
  } id_ex_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: sign-extends the I/S/B/U/J field of an instruction.
// Ports: i_instr (bits 31:7), i_type (format) -> o_imm (32-bit immediate).
module imm_gen
  import constants::*;
(
  input  logic [31:7] i_instr,
  input  imm_type_e   i_type,
  output logic [31:0] o_imm
);

  logic w_s;

  assign w_s = i_instr[31];

  always_comb begin
    o_imm = '0;
    unique case (i_type)
      IMM_I: o_imm = {{20{w_s}}, i_instr[31:20]};
      IMM_S: o_imm = {{20{w_s}}, i_instr[31:25],
                      i_instr[11:7]};
      IMM_B: o_imm = {{19{w_s}}, w_s, i_instr[7],
                      i_instr[30:25], i_instr[11:8],
                      1'b0};
      IMM_U: o_imm = {i_instr[31:12], 12'b0};
      IMM_J: o_imm = {{11{w_s}}, w_s, i_instr[19:12],
                      i_instr[20], i_instr[30:21],
                      1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes fetch output into ALU op, operands and
// writeback/branch control, held in one skid-free output register.
// Ports: clk_i/rst_i (sync active-high), flush_i, fetch handshake
// (in_valid_i/in_ready_o, instr_i, pc_i), register-file read
// (rs*_addr_o, rs*_data_i), execute handshake (out_valid_o/out_ready_i)
// and the registered decode outputs.
module decode_stage
  import constants::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output alu_op_e         alu_op_o,
  output logic [XLEN-1:0] oper1_o,
  output logic [XLEN-1:0] oper2_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      rd_o,
  output logic            rd_we_o,
  output logic            is_branch_o,
  output logic            is_jump_o,
  output logic            is_load_o,
  output logic            is_store_o,
  output logic            illegal_o
);

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_pc4;
  logic [31:0] w_imm;
  logic [31:0] w_shamt;
  imm_type_e   w_imm_type;
  id_ex_t      w_dec;
  logic        w_ill;
  logic        w_wr;
  logic        w_load;

  id_ex_t      r_q;
  logic        r_valid;

  assign w_opc   = instr_i[6:0];
  assign w_f3    = instr_i[14:12];
  assign w_f7    = instr_i[31:25];
  assign w_pc4   = pc_i + 32'd4;
  assign w_shamt = {27'b0, instr_i[24:20]};

  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];

  always_comb begin
    w_imm_type = IMM_I;
    case (w_opc)
      OPC_STORE:  w_imm_type = IMM_S;
      OPC_BRANCH: w_imm_type = IMM_B;
      OPC_LUI:    w_imm_type = IMM_U;
      OPC_AUIPC:  w_imm_type = IMM_U;
      OPC_JAL:    w_imm_type = IMM_J;
      default:    w_imm_type = IMM_I;
    endcase
  end

  imm_gen u_imm_gen (
    .i_instr (instr_i[31:7]),
    .i_type  (w_imm_type),
    .o_imm   (w_imm)
  );

  always_comb begin
    w_dec            = '0;
    w_dec.alu_op     = ALU_PASS;
    w_dec.pc         = pc_i;
    w_dec.rd         = instr_i[11:7];
    w_dec.store_data = rs2_data_i;
    w_ill            = 1'b0;
    w_wr             = 1'b0;

    case (w_opc)
      OPC_OP: begin
        w_dec.oper1 = rs1_data_i;
        w_dec.oper2 = rs2_data_i;
        w_wr        = 1'b1;
        case ({w_f7, w_f3})
          {F7_ZERO, 3'b000}: w_dec.alu_op = ALU_ADD;
          {F7_ALT,  3'b000}: w_dec.alu_op = ALU_SUB;
          {F7_ZERO, 3'b001}: w_dec.alu_op = ALU_SLL;
          {F7_ZERO, 3'b010}: w_dec.alu_op = ALU_SLT;
          {F7_ZERO, 3'b011}: w_dec.alu_op = ALU_SLTU;
          {F7_ZERO, 3'b100}: w_dec.alu_op = ALU_XOR;
          {F7_ZERO, 3'b101}: w_dec.alu_op = ALU_SRL;
          {F7_ALT,  3'b101}: w_dec.alu_op = ALU_SRA;
          {F7_ZERO, 3'b110}: w_dec.alu_op = ALU_OR;
          {F7_ZERO, 3'b111}: w_dec.alu_op = ALU_AND;
          default:           w_ill        = 1'b1;
        endcase
      end

      OPC_OP_IMM: begin
        w_dec.oper1 = rs1_data_i;
        w_dec.oper2 = w_imm;
        w_dec.imm   = w_imm;
        w_wr        = 1'b1;
        unique case (w_f3)
          3'b000: w_dec.alu_op = ALU_ADD;
          3'b010: w_dec.alu_op = ALU_SLT;
          3'b011: w_dec.alu_op = ALU_SLTU;
          3'b100: w_dec.alu_op = ALU_XOR;
          3'b110: w_dec.alu_op = ALU_OR;
          3'b111: w_dec.alu_op = ALU_AND;
          3'b001: begin
            // shifts take only the 5-bit shamt, not funct7
            w_dec.oper2 = w_shamt;
            if (w_f7 == F7_ZERO) w_dec.alu_op = ALU_SLL;
            else                 w_ill        = 1'b1;
          end
          3'b101: begin
            w_dec.oper2 = w_shamt;
            if (w_f7 == F7_ZERO)     w_dec.alu_op = ALU_SRL;
            else if (w_f7 == F7_ALT) w_dec.alu_op = ALU_SRA;
            else                     w_ill        = 1'b1;
          end
          default: w_ill = 1'b1;
        endcase
      end

      OPC_LUI: begin
        w_dec.oper1 = w_imm;
        w_dec.imm   = w_imm;
        w_wr        = 1'b1;
      end

      OPC_AUIPC: begin
        w_dec.alu_op = ALU_ADD;
        w_dec.oper1  = pc_i;
        w_dec.oper2  = w_imm;
        w_dec.imm    = w_imm;
        w_wr         = 1'b1;
      end

      OPC_LOAD: begin
        w_dec.alu_op  = ALU_ADD;
        w_dec.oper1   = rs1_data_i;
        w_dec.oper2   = w_imm;
        w_dec.imm     = w_imm;
        w_dec.is_load = 1'b1;
        w_wr          = 1'b1;
      end

      OPC_STORE: begin
        w_dec.alu_op   = ALU_ADD;
        w_dec.oper1    = rs1_data_i;
        w_dec.oper2    = w_imm;
        w_dec.imm      = w_imm;
        w_dec.is_store = 1'b1;
      end

      OPC_BRANCH: begin
        w_dec.oper1     = rs1_data_i;
        w_dec.oper2     = rs2_data_i;
        w_dec.imm       = w_imm;
        w_dec.is_branch = 1'b1;
        unique case (w_f3)
          3'b000:  w_dec.alu_op = ALU_EQ;
          3'b001:  w_dec.alu_op = ALU_NE;
          3'b100:  w_dec.alu_op = ALU_SLT;
          3'b101:  w_dec.alu_op = ALU_SGE;
          3'b110:  w_dec.alu_op = ALU_SLTU;
          3'b111:  w_dec.alu_op = ALU_SGEU;
          default: w_ill        = 1'b1;
        endcase
      end

      OPC_JAL: begin
        w_dec.oper1   = w_pc4;
        w_dec.imm     = w_imm;
        w_dec.is_jump = 1'b1;
        w_wr          = 1'b1;
      end

      OPC_JALR: begin
        // execute computes the target from rs1 + imm
        w_dec.oper1      = w_pc4;
        w_dec.imm        = w_imm;
        w_dec.store_data = rs1_data_i;
        w_dec.is_jump    = 1'b1;
        w_wr             = 1'b1;
        if (w_f3 != 3'b000) w_ill = 1'b1;
      end

      default: w_ill = 1'b1;
    endcase

    if (w_ill) begin
      w_dec.alu_op    = ALU_PASS;
      w_dec.oper1     = '0;
      w_dec.oper2     = '0;
      w_dec.imm       = '0;
      w_dec.is_branch = 1'b0;
      w_dec.is_jump   = 1'b0;
      w_dec.is_load   = 1'b0;
      w_dec.is_store  = 1'b0;
      w_dec.illegal   = 1'b1;
      w_dec.rd_we     = 1'b0;
    end else begin
      w_dec.rd_we = w_wr && (w_dec.rd != 5'd0);
    end
  end

  assign in_ready_o = !r_valid || out_ready_i;
  assign w_load     = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid        <= 1'b0;
      r_q            <= '0;
      r_q.alu_op     <= ALU_PASS;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_q     <= w_dec;
    end else if (out_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid_o  = r_valid;
  assign alu_op_o     = r_q.alu_op;
  assign oper1_o      = r_q.oper1;
  assign oper2_o      = r_q.oper2;
  assign store_data_o = r_q.store_data;
  assign imm_o        = r_q.imm;
  assign pc_o         = r_q.pc;
  assign rd_o         = r_q.rd;
  assign rd_we_o      = r_q.rd_we;
  assign is_branch_o  = r_q.is_branch;
  assign is_jump_o    = r_q.is_jump;
  assign is_load_o    = r_q.is_load;
  assign is_store_o   = r_q.is_store;
  assign illegal_o    = r_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: hand-encoded RV32I vectors,
// handshake backpressure, flush and reset-in-stall scenarios.
module tb_decode_stage;
  import constants::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] instr_i = '0;
  logic [31:0] pc_i = '0;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  alu_op_e     alu_op_o;
  logic [31:0] oper1_o;
  logic [31:0] oper2_o;
  logic [31:0] store_data_o;
  logic [31:0] imm_o;
  logic [31:0] pc_o;
  logic [4:0]  rd_o;
  logic        rd_we_o;
  logic        is_branch_o;
  logic        is_jump_o;
  logic        is_load_o;
  logic        is_store_o;
  logic        illegal_o;

  int n_vec = 0;
  int n_err = 0;
  logic [4:0] xfer_q[$];

  decode_stage #(.XLEN(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .instr_i      (instr_i),
    .pc_i         (pc_i),
    .rs1_addr_o   (rs1_addr_o),
    .rs2_addr_o   (rs2_addr_o),
    .rs1_data_i   (rs1_data_i),
    .rs2_data_i   (rs2_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .alu_op_o     (alu_op_o),
    .oper1_o      (oper1_o),
    .oper2_o      (oper2_o),
    .store_data_o (store_data_o),
    .imm_o        (imm_o),
    .pc_o         (pc_o),
    .rd_o         (rd_o),
    .rd_we_o      (rd_we_o),
    .is_branch_o  (is_branch_o),
    .is_jump_o    (is_jump_o),
    .is_load_o    (is_load_o),
    .is_store_o   (is_store_o),
    .illegal_o    (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i)
    if (out_valid_o && out_ready_i) xfer_q.push_back(rd_o);

  task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2);
    @(negedge clk_i);
    instr_i    = ins;
    pc_i       = pc;
    rs1_data_i = r1;
    rs2_data_i = r2;
    in_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    n_vec++;
    if ({out_valid_o, alu_op_o, in_ready_o} !== {1'b0, ALU_PASS, 1'b1}) begin
      n_err++;
      $display("FAIL reset_ctl: got v=%b op=%0d rdy=%b want v=0 op=0 rdy=1",
               out_valid_o, alu_op_o, in_ready_o);
    end
    n_vec++;
    if ({oper1_o, oper2_o, imm_o, rd_o, rd_we_o, illegal_o} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got %h %h %h rd=%0d we=%b ill=%b want all 0",
               oper1_o, oper2_o, imm_o, rd_o, rd_we_o, illegal_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_alu_rr();
    @(negedge clk_i);
    instr_i    = 32'h002081B3;
    pc_i       = 32'h40;
    rs1_data_i = 32'd5;
    rs2_data_i = 32'd7;
    in_valid_i = 1'b1;
    #1;
    n_vec++;
    if ({rs1_addr_o, rs2_addr_o} !== {5'd1, 5'd2}) begin
      n_err++;
      $display("FAIL rf_addr: got %0d/%0d want 1/2", rs1_addr_o, rs2_addr_o);
    end
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    n_vec++;
    if ({out_valid_o, alu_op_o, oper1_o, oper2_o, rd_o, rd_we_o, pc_o} !==
        {1'b1, ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 32'h40}) begin
      n_err++;
      $display("FAIL add: got v=%b op=%0d %h %h rd=%0d we=%b pc=%h",
               out_valid_o, alu_op_o, oper1_o, oper2_o, rd_o, rd_we_o, pc_o);
    end
    send(32'h402081B3, 32'h44, 32'd9, 32'd4);
    n_vec++;
    if ({alu_op_o, oper1_o, oper2_o} !== {ALU_SUB, 32'd9, 32'd4}) begin
      n_err++;
      $display("FAIL sub: got op=%0d %h %h want op=%0d 9 4",
               alu_op_o, oper1_o, oper2_o, ALU_SUB);
    end
    send(32'h022081B3, 32'h48, 32'd1, 32'd2);
    n_vec++;
    if ({illegal_o, rd_we_o, alu_op_o} !== {1'b1, 1'b0, ALU_PASS}) begin
      n_err++;
      $display("FAIL op_bad_f7: got ill=%b we=%b op=%0d want 1 0 0",
               illegal_o, rd_we_o, alu_op_o);
    end
  endtask

  task automatic test_op_imm();
    send(32'h40335293, 32'h50, 32'h80000000, 32'd0);
    n_vec++;
    if ({alu_op_o, oper1_o, oper2_o, rd_o, rd_we_o, illegal_o} !==
        {ALU_SRA, 32'h80000000, 32'd3, 5'd5, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL srai: got op=%0d %h %h rd=%0d we=%b ill=%b",
               alu_op_o, oper1_o, oper2_o, rd_o, rd_we_o, illegal_o);
    end
    send(32'hFE335293, 32'h54, 32'h80000000, 32'd0);
    n_vec++;
    if ({illegal_o, rd_we_o, alu_op_o} !== {1'b1, 1'b0, ALU_PASS}) begin
      n_err++;
      $display("FAIL srai_bad_f7: got ill=%b we=%b op=%0d want 1 0 0",
               illegal_o, rd_we_o, alu_op_o);
    end
    send(32'hFFF00513, 32'h58, 32'd0, 32'd0);
    n_vec++;
    if ({alu_op_o, oper2_o, imm_o, rd_o} !==
        {ALU_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10}) begin
      n_err++;
      $display("FAIL addi_neg: got op=%0d %h %h rd=%0d",
               alu_op_o, oper2_o, imm_o, rd_o);
    end
  endtask

  task automatic test_branch();
    send(32'hFE20DCE3, 32'h60, 32'd11, 32'd22);
    n_vec++;
    if ({alu_op_o, is_branch_o, imm_o, rd_we_o, oper1_o, oper2_o} !==
        {ALU_SGE, 1'b1, 32'hFFFFFFF8, 1'b0, 32'd11, 32'd22}) begin
      n_err++;
      $display("FAIL bge: got op=%0d br=%b imm=%h we=%b %h %h",
               alu_op_o, is_branch_o, imm_o, rd_we_o, oper1_o, oper2_o);
    end
    send(32'h0020E463, 32'h64, 32'd1, 32'd2);
    n_vec++;
    if ({alu_op_o, is_branch_o, imm_o} !== {ALU_SLTU, 1'b1, 32'd8}) begin
      n_err++;
      $display("FAIL bltu: got op=%0d br=%b imm=%h want op=%0d 1 8",
               alu_op_o, is_branch_o, imm_o, ALU_SLTU);
    end
    send(32'h0020A463, 32'h68, 32'd1, 32'd2);
    n_vec++;
    if ({illegal_o, is_branch_o, alu_op_o} !== {1'b1, 1'b0, ALU_PASS}) begin
      n_err++;
      $display("FAIL br_f3_010: got ill=%b br=%b op=%0d want 1 0 0",
               illegal_o, is_branch_o, alu_op_o);
    end
  endtask

  task automatic test_upper();
    send(32'h12345037, 32'h70, 32'd0, 32'd0);
    n_vec++;
    if ({alu_op_o, oper1_o, rd_we_o, illegal_o} !==
        {ALU_PASS, 32'h12345000, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL lui_x0: got op=%0d %h we=%b ill=%b",
               alu_op_o, oper1_o, rd_we_o, illegal_o);
    end
    send(32'h00001097, 32'h100, 32'd0, 32'd0);
    n_vec++;
    if ({alu_op_o, oper1_o, oper2_o, rd_we_o} !==
        {ALU_ADD, 32'h100, 32'h1000, 1'b1}) begin
      n_err++;
      $display("FAIL auipc: got op=%0d %h %h we=%b",
               alu_op_o, oper1_o, oper2_o, rd_we_o);
    end
  endtask

  task automatic test_jump_mem();
    send(32'h008000EF, 32'hFFFFFFFC, 32'd0, 32'd0);
    n_vec++;
    if ({alu_op_o, oper1_o, imm_o, is_jump_o, rd_we_o} !==
        {ALU_PASS, 32'h0, 32'd8, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL jal_wrap: got op=%0d %h imm=%h j=%b we=%b",
               alu_op_o, oper1_o, imm_o, is_jump_o, rd_we_o);
    end
    send(32'h004280E7, 32'h200, 32'hABCD0000, 32'd0);
    n_vec++;
    if ({oper1_o, imm_o, store_data_o, is_jump_o, illegal_o} !==
        {32'h204, 32'd4, 32'hABCD0000, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL jalr: got %h imm=%h sd=%h j=%b ill=%b",
               oper1_o, imm_o, store_data_o, is_jump_o, illegal_o);
    end
    send(32'hFE20AE23, 32'h210, 32'h1000, 32'hCAFEF00D);
    n_vec++;
    if ({alu_op_o, oper1_o, oper2_o, store_data_o, is_store_o, rd_we_o} !==
        {ALU_ADD, 32'h1000, 32'hFFFFFFFC, 32'hCAFEF00D, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL sw: got op=%0d %h %h sd=%h st=%b we=%b",
               alu_op_o, oper1_o, oper2_o, store_data_o, is_store_o, rd_we_o);
    end
    send(32'h0080A283, 32'h214, 32'h2000, 32'd0);
    n_vec++;
    if ({alu_op_o, oper1_o, oper2_o, is_load_o, rd_o, rd_we_o} !==
        {ALU_ADD, 32'h2000, 32'd8, 1'b1, 5'd5, 1'b1}) begin
      n_err++;
      $display("FAIL lw: got op=%0d %h %h ld=%b rd=%0d we=%b",
               alu_op_o, oper1_o, oper2_o, is_load_o, rd_o, rd_we_o);
    end
    send(32'h00000000, 32'h218, 32'd0, 32'd0);
    n_vec++;
    if ({illegal_o, alu_op_o, rd_we_o, is_branch_o, is_jump_o,
         is_load_o, is_store_o} !== {1'b1, ALU_PASS, 5'b0}) begin
      n_err++;
      $display("FAIL undef_opc: got ill=%b op=%0d we=%b flags=%b%b%b%b",
               illegal_o, alu_op_o, rd_we_o, is_branch_o, is_jump_o,
               is_load_o, is_store_o);
    end
  endtask

  task automatic test_back_to_back();
    out_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    xfer_q.delete();
    @(negedge clk_i);
    out_ready_i = 1'b0;
    instr_i     = 32'h00100513;
    in_valid_i  = 1'b1;
    @(posedge clk_i);
    #1;
    instr_i = 32'h00200593;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({out_valid_o, in_ready_o, rd_o, oper2_o} !==
          {1'b1, 1'b0, 5'd10, 32'd1}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got v=%b rdy=%b rd=%0d %h",
                 i, out_valid_o, in_ready_o, rd_o, oper2_o);
      end
      @(posedge clk_i);
      #1;
    end
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    instr_i = 32'h00300613;
    n_vec++;
    if ({out_valid_o, rd_o, oper2_o} !== {1'b1, 5'd11, 32'd2}) begin
      n_err++;
      $display("FAIL b2b_second: got v=%b rd=%0d %h want 1 11 2",
               out_valid_o, rd_o, oper2_o);
    end
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    n_vec++;
    if ({out_valid_o, rd_o} !== {1'b1, 5'd12}) begin
      n_err++;
      $display("FAIL b2b_third: got v=%b rd=%0d want 1 12",
               out_valid_o, rd_o);
    end
    @(posedge clk_i);
    #1;
    n_vec++;
    if (out_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain: got v=%b want 0", out_valid_o);
    end
    n_vec++;
    if (xfer_q.size() != 3 ||
        {xfer_q[0], xfer_q[1], xfer_q[2]} !== {5'd10, 5'd11, 5'd12}) begin
      n_err++;
      $display("FAIL b2b_xfers: got %0d transfers want 3 (10,11,12)",
               xfer_q.size());
    end
  endtask

  task automatic test_flush();
    out_ready_i = 1'b0;
    send(32'h002081B3, 32'h300, 32'd1, 32'd1);
    @(negedge clk_i);
    out_ready_i = 1'b1;
    flush_i     = 1'b1;
    instr_i     = 32'h00100513;
    in_valid_i  = 1'b1;
    #1;
    n_vec++;
    if (in_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL flush_rdy: got rdy=%b want 1", in_ready_o);
    end
    @(posedge clk_i);
    #1;
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    n_vec++;
    if (out_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush_drop: got v=%b want 0", out_valid_o);
    end
  endtask

  task automatic test_reset_stall();
    out_ready_i = 1'b0;
    send(32'h002081B3, 32'h400, 32'd5, 32'd7);
    n_vec++;
    if ({out_valid_o, alu_op_o} !== {1'b1, ALU_ADD}) begin
      n_err++;
      $display("FAIL pre_rst_hold: got v=%b op=%0d want 1 %0d",
               out_valid_o, alu_op_o, ALU_ADD);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    n_vec++;
    if ({out_valid_o, alu_op_o, oper1_o, rd_o} !==
        {1'b0, ALU_PASS, 32'd0, 5'd0}) begin
      n_err++;
      $display("FAIL rst_stall: got v=%b op=%0d %h rd=%0d want 0 0 0 0",
               out_valid_o, alu_op_o, oper1_o, rd_o);
    end
    @(negedge clk_i);
    rst_i       = 1'b0;
    out_ready_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alu_rr();
    test_op_imm();
    test_branch();
    test_upper();
    test_jump_mem();
    test_back_to_back();
    test_flush();
    test_reset_stall();
    repeat (2) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined instruction decode stage that produces the operation and operands consumed by the execute-stage ALU. Accepts a 32-bit RV32I instruction plus PC from fetch over a valid/ready handshake, reads two register-file ports, generates the immediate, and registers an `alu_op_e` selector, two 32-bit operands and writeback/branch control toward execute. Sits between fetch and execute; one instruction per cycle at full throughput.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `flush_i`  in  1  discard the held instruction (branch taken / trap).
- `in_valid_i`  in  1  fetch presents an instruction.
- `in_ready_o`  out  1  stage can accept this cycle.
- `instr_i`  in  32  raw instruction.
- `pc_i`  in  32  PC of `instr_i`.
- `rs1_addr_o`, `rs2_addr_o`  out  5 each  register-file read addresses, combinational from `instr_i[19:15]` / `instr_i[24:20]`.
- `rs1_data_i`, `rs2_data_i`  in  32 each  register-file read data, combinational, same cycle.
- `out_valid_o`  out  1  decoded instruction held for execute.
- `out_ready_i`  in  1  execute accepts.
- `alu_op_o`  out  `alu_op_e`  ALU operation select.
- `oper1_o`, `oper2_o`  out  32 each  ALU operands.
- `store_data_o`  out  32  rs2 value for stores / branch targets.
- `imm_o`  out  32  sign-extended immediate.
- `pc_o`  out  32  PC of held instruction.
- `rd_o`  out  5  destination register.
- `rd_we_o`  out  1  writeback enable; forced 0 when `rd_o` = 0.
- `is_branch_o`, `is_jump_o`, `is_load_o`, `is_store_o`  out  1 each  class flags.
- `illegal_o`  out  1  instruction not decodable.

## Operation
- Opcode map (decode of `instr_i[6:0]`, funct3, funct7):
  - OP (0110011): rs1/rs2 → ADD/SUB (f7[5]), SLL, SLT, SLTU, XOR, SRL/SRA (f7[5]), OR, AND. Any other funct7 → illegal.
  - OP-IMM (0010011): rs1/I-imm; SLLI needs f7=0000000; SRLI/SRAI f7=0000000/0100000; no SUBI.
  - LUI: op PASS, oper1 = U-imm. AUIPC: ADD, oper1 = pc, oper2 = U-imm.
  - LOAD / STORE: ADD, rs1 + I-imm / S-imm; store rd_we=0.
  - BRANCH: funct3 000 EQ, 001 NE, 100 SLT, 101 SGE, 110 SLTU, 111 SGEU (signed/unsigned per RV32I beq/bne/blt/bge/bltu/bgeu semantics); operands rs1/rs2; imm = B-imm; rd_we=0; 010/011 → illegal.
  - JAL: op PASS, oper1 = pc + 4, imm = J-imm. JALR (funct3 000 only): oper1 = pc + 4, imm = I-imm, `store_data_o` = rs1.
  - Anything else: `illegal_o`=1, op PASS, rd_we=0, all class flags 0.
- Immediates sign-extended from instruction bit 31; B/J imm bit 0 = 0; U-imm low 12 bits zero. pc + 4 wraps modulo 2^32.
- Single output register; load enable = `in_valid_i && in_ready_o`.

## Timing
- `in_ready_o` = `!out_valid_o || out_ready_i` (combinational; no dependence on `in_valid_i`).
- Latency 1: accepted in cycle N → outputs valid from cycle N+1.
- Output holds stable while `out_valid_o && !out_ready_i`.
- Simultaneous drain and load: new instruction replaces old, `out_valid_o` stays 1 — zero bubble.
- `flush_i`: next cycle `out_valid_o`=0, input in same cycle is dropped (flush beats load); `in_ready_o` not gated by flush.
- Reset: `out_valid_o`=0, `alu_op_o`=ALU_PASS, all other registered outputs 0. Reset mid-stall discards the held instruction.

## Structure
- `constants` package: existing `alu_op_e`; add opcode localparams (`OPC_OP`, `OPC_OP_IMM`, `OPC_LUI`, `OPC_AUIPC`, `OPC_LOAD`, `OPC_STORE`, `OPC_BRANCH`, `OPC_JAL`, `OPC_JALR`) and an `imm_type_e` (I, S, B, U, J).
- Sub-module `imm_gen`: combinational, `instr` + `imm_type_e` → 32-bit immediate.

## Test plan
- `add x3,x1,x2` (0x002081B3), rs1=5, rs2=7 → next cycle ALU_ADD, oper1=5, oper2=7, rd=3, rd_we=1.
- `srai x5,x6,3` (0x40335293), rs1=0x80000000 → ALU_SRA, oper2=3; funct7=0x7F variant → illegal_o=1, rd_we=0.
- `bge x1,x2,-8` (0xFE20DCE3) → ALU_SGE, is_branch=1, imm=0xFFFFFFF8, rd_we=0.
- `lui x0,0x12345` → rd_we=0 despite LUI; `auipc x1,1` at pc=0x100 → oper1=0x100, oper2=0x1000.
- Backpressure: hold `out_ready_i`=0 three cycles with continuous input → outputs stable, `in_ready_o`=0; release → one transfer per cycle, no loss/duplication.
- `flush_i` with `in_valid_i`=1 and a held instruction → `out_valid_o`=0 next cycle; assert `rst_i` during stall → `out_valid_o`=0, `alu_op_o`=ALU_PASS.
